// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand_stage
// Description : ID->EX pipeline boundary. Resolves register-file operands
//               with EX/MEM/WB forwarding, detects load-use hazards, requests
//               a one-cycle stall, and registers operands/control into the
//               ID/EX pipeline register with bubble, flush and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs_addr,
   input  logic [AW-1:0] id_rt_addr,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic [AW-1:0] id_rd_addr,
   input  logic          id_wr_en,
   input  logic          id_is_load,
   input  logic [DW-1:0] rf_r1_dout,
   input  logic [DW-1:0] rf_r2_dout,
   input  logic [DW-1:0] ex_alu_result,
   input  logic          mem_wr,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_wr,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          flush,
   output logic          stall_out,
   output logic          ex_valid,
   output logic [DW-1:0] ex_rs_val,
   output logic [DW-1:0] ex_rt_val,
   output logic [AW-1:0] ex_rd_addr,
   output logic          ex_wr_en,
   output logic          ex_is_load,
   output logic [CW-1:0] stall_cnt
);

   logic [DW-1:0] w_rs_res;
   logic [DW-1:0] w_rt_res;
   logic          w_hz;

   // Youngest producer wins: EX (non-load only) > MEM > WB > register file.
   // WB must be checked because the reg file returns the pre-write value
   // during the cycle the write is happening.
   function automatic logic [DW-1:0] resolve(input logic [AW-1:0] addr,
                                             input logic [DW-1:0] rf_val);
      logic [DW-1:0] v;
      if (addr == '0)
         v = '0;
      else if (ex_valid && ex_wr_en && !ex_is_load && (ex_rd_addr == addr))
         v = ex_alu_result;
      else if (mem_wr && (mem_addr == addr))
         v = mem_data;
      else if (wb_wr && (wb_addr == addr))
         v = wb_data;
      else
         v = rf_val;
      return v;
   endfunction

   // Operand resolution for both sources.
   always_comb begin
      w_rs_res = resolve(id_rs_addr, rf_r1_dout);
      w_rt_res = resolve(id_rt_addr, rf_r2_dout);
   end

   // Load-use hazard: a load in EX cannot forward, so a dependent ID
   // instruction waits one cycle and then picks the value up from MEM.
   always_comb begin
      w_hz = id_valid && ex_valid && ex_is_load && ex_wr_en &&
             (ex_rd_addr != '0) &&
             ((id_uses_rs && (id_rs_addr == ex_rd_addr)) ||
              (id_uses_rt && (id_rt_addr == ex_rd_addr)));
      stall_out = w_hz && !flush;
   end

   // ID/EX pipeline register: flush beats hazard; both insert a bubble.
   // Operands and rd are left untouched on a bubble since ex_valid=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_rs_val  <= '0;
         ex_rt_val  <= '0;
         ex_rd_addr <= '0;
         ex_wr_en   <= 1'b0;
         ex_is_load <= 1'b0;
         stall_cnt  <= '0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_wr_en   <= 1'b0;
         ex_is_load <= 1'b0;
      end else if (w_hz) begin
         ex_valid   <= 1'b0;
         ex_wr_en   <= 1'b0;
         ex_is_load <= 1'b0;
         if (stall_cnt != '1)
            stall_cnt <= stall_cnt + CW'(1);
      end else begin
         ex_valid   <= id_valid;
         ex_rd_addr <= id_rd_addr;
         ex_wr_en   <= id_wr_en && id_valid;
         ex_is_load <= id_is_load && id_valid;
         ex_rs_val  <= w_rs_res;
         ex_rt_val  <= w_rt_res;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_operand_stage
// Description : Directed self-checking bench for id_ex_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs_addr;
   logic [AW-1:0] id_rt_addr;
   logic          id_uses_rs;
   logic          id_uses_rt;
   logic [AW-1:0] id_rd_addr;
   logic          id_wr_en;
   logic          id_is_load;
   logic [DW-1:0] rf_r1_dout;
   logic [DW-1:0] rf_r2_dout;
   logic [DW-1:0] ex_alu_result;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          wb_wr;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          flush;
   logic          stall_out;
   logic          ex_valid;
   logic [DW-1:0] ex_rs_val;
   logic [DW-1:0] ex_rt_val;
   logic [AW-1:0] ex_rd_addr;
   logic          ex_wr_en;
   logic          ex_is_load;
   logic [CW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
      .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout),
      .ex_alu_result(ex_alu_result),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
      .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .stall_out(stall_out),
      .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rd_addr = 0; id_wr_en = 0; id_is_load = 0;
      rf_r1_dout = 0; rf_r2_dout = 0; ex_alu_result = 0;
      mem_wr = 0; mem_addr = 0; mem_data = 0;
      wb_wr = 0; wb_addr = 0; wb_data = 0; flush = 0;
   endtask

   // Present an instruction in ID (no source reads).
   task automatic issue(input logic [AW-1:0] rd, input logic wr, input logic ld);
      idle();
      id_valid = 1; id_rd_addr = rd; id_wr_en = wr; id_is_load = ld;
   endtask

   initial begin
      // Reset with random inputs
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         id_valid = 1'($urandom); id_rs_addr = AW'($urandom); id_rt_addr = AW'($urandom);
         id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_rd_addr = AW'($urandom);
         id_wr_en = 1'($urandom); id_is_load = 1'($urandom);
         rf_r1_dout = $urandom; rf_r2_dout = $urandom; ex_alu_result = $urandom;
         mem_wr = 1'($urandom); mem_addr = AW'($urandom); mem_data = $urandom;
         wb_wr = 1'($urandom); wb_addr = AW'($urandom); wb_data = $urandom;
         flush = 1'($urandom);
      end
      step();
      check("rst_valid", 64'(ex_valid), 64'd0);
      check("rst_rs", 64'(ex_rs_val), 64'd0);
      check("rst_rt", 64'(ex_rt_val), 64'd0);
      check("rst_rd", 64'(ex_rd_addr), 64'd0);
      check("rst_wr", 64'(ex_wr_en), 64'd0);
      check("rst_ld", 64'(ex_is_load), 64'd0);
      check("rst_cnt", 64'(stall_cnt), 64'd0);
      check("rst_stall", 64'(stall_out), 64'd0);
      rst = 0;

      // Plain register-file read, no producers
      issue(5'd7, 1'b1, 1'b0);
      id_uses_rs = 1; id_rs_addr = 5'd3; rf_r1_dout = 32'h11;
      step();
      check("basic_valid", 64'(ex_valid), 64'd1);
      check("basic_rs", 64'(ex_rs_val), 64'h11);
      check("basic_rd", 64'(ex_rd_addr), 64'd7);
      check("basic_wr", 64'(ex_wr_en), 64'd1);

      // Put a writer of r4 into EX
      issue(5'd4, 1'b1, 1'b0);
      step();
      // Forwarding priority on both sources
      issue(5'd0, 1'b0, 1'b0);
      id_uses_rs = 1; id_rs_addr = 5'd4; id_uses_rt = 1; id_rt_addr = 5'd4;
      rf_r1_dout = 32'h44; rf_r2_dout = 32'h45; ex_alu_result = 32'hAA;
      mem_wr = 1; mem_addr = 5'd4; mem_data = 32'hBB;
      wb_wr = 1; wb_addr = 5'd4; wb_data = 32'hCC;
      #1 check("fwd_no_stall", 64'(stall_out), 64'd0);
      step();
      check("fwd_ex_rs", 64'(ex_rs_val), 64'hAA);
      check("fwd_ex_rt", 64'(ex_rt_val), 64'hAA);
      step();   // EX now holds a non-writer
      check("fwd_mem_rs", 64'(ex_rs_val), 64'hBB);
      check("fwd_mem_rt", 64'(ex_rt_val), 64'hBB);
      mem_wr = 0;
      step();
      check("fwd_wb_rs", 64'(ex_rs_val), 64'hCC);
      wb_wr = 0;
      step();
      check("fwd_rf_rs", 64'(ex_rs_val), 64'h44);
      check("fwd_rf_rt", 64'(ex_rt_val), 64'h45);

      // r0 with an EX writer of r0, then an EX load of r0
      issue(5'd0, 1'b1, 1'b0);
      step();
      issue(5'd0, 1'b1, 1'b1);
      id_uses_rs = 1; id_rs_addr = 5'd0; ex_alu_result = 32'hFF;
      mem_wr = 1; mem_addr = 5'd0; mem_data = 32'h12;
      step();
      check("r0_rs", 64'(ex_rs_val), 64'd0);
      check("r0_ld_in_ex", 64'(ex_is_load), 64'd1);
      issue(5'd0, 1'b0, 1'b0);
      id_uses_rs = 1; id_uses_rt = 1;
      #1 check("r0_no_stall", 64'(stall_out), 64'd0);
      step();
      check("r0_valid", 64'(ex_valid), 64'd1);
      check("r0_cnt", 64'(stall_cnt), 64'd0);

      // Load-use hazard on rt
      issue(5'd5, 1'b1, 1'b1);
      step();
      issue(5'd6, 1'b1, 1'b0);
      id_uses_rs = 1; id_rs_addr = 5'd1; id_uses_rt = 1; id_rt_addr = 5'd5;
      rf_r1_dout = 32'h01; rf_r2_dout = 32'h99;
      #1 check("lu_stall", 64'(stall_out), 64'd1);
      step();
      check("lu_bubble", 64'(ex_valid), 64'd0);
      check("lu_bubble_wr", 64'(ex_wr_en), 64'd0);
      check("lu_cnt", 64'(stall_cnt), 64'd1);
      mem_wr = 1; mem_addr = 5'd5; mem_data = 32'h55;
      #1 check("lu_stall_once", 64'(stall_out), 64'd0);
      step();
      check("lu_valid", 64'(ex_valid), 64'd1);
      check("lu_rt", 64'(ex_rt_val), 64'h55);
      check("lu_rs", 64'(ex_rs_val), 64'h01);
      check("lu_rd", 64'(ex_rd_addr), 64'd6);

      // Hazard coinciding with flush
      issue(5'd8, 1'b1, 1'b1);
      step();
      issue(5'd9, 1'b1, 1'b0);
      id_uses_rs = 1; id_rs_addr = 5'd8; flush = 1;
      #1 check("fl_stall", 64'(stall_out), 64'd0);
      step();
      check("fl_bubble", 64'(ex_valid), 64'd0);
      check("fl_cnt", 64'(stall_cnt), 64'd1);

      // Reset asserted during a stall
      issue(5'd9, 1'b1, 1'b1);
      step();
      issue(5'd10, 1'b1, 1'b0);
      id_uses_rs = 1; id_rs_addr = 5'd9;
      #1 check("rs_stall", 64'(stall_out), 64'd1);
      rst = 1;
      step();
      check("rs_valid", 64'(ex_valid), 64'd0);
      check("rs_ld", 64'(ex_is_load), 64'd0);
      check("rs_rs", 64'(ex_rs_val), 64'd0);
      check("rs_cnt", 64'(stall_cnt), 64'd0);
      check("rs_stall_out", 64'(stall_out), 64'd0);
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
